// File: rtl/rasterizer_scan_controller.sv
// Upstream driver for the triangle intersection detector: clips the bounding box to
// the screen, sweeps it one point per clock and turns verdicts into pixel writes.
module rasterizer_scan_controller #(
    parameter int HORIZ_RESOLUTION = 80,
    parameter int VERT_RESOLUTION  = 60,
    parameter int DET_LATENCY      = 2,
    localparam int XW = $clog2(HORIZ_RESOLUTION),
    localparam int YW = $clog2(VERT_RESOLUTION)
) (
    input  logic          i_clk,
    input  logic          i_arst_n,
    input  logic          i_tri_valid,
    output logic          o_tri_ready,
    input  logic [XW-1:0] i_tri_x0,
    input  logic [XW-1:0] i_tri_x1,
    input  logic [XW-1:0] i_tri_x2,
    input  logic [YW-1:0] i_tri_y0,
    input  logic [YW-1:0] i_tri_y1,
    input  logic [YW-1:0] i_tri_y2,
    output logic          o_det_load,
    output logic [XW-1:0] o_det_x0,
    output logic [XW-1:0] o_det_x1,
    output logic [XW-1:0] o_det_x2,
    output logic [YW-1:0] o_det_y0,
    output logic [YW-1:0] o_det_y1,
    output logic [YW-1:0] o_det_y2,
    input  logic          i_det_triangle_loaded,
    output logic [XW-1:0] o_det_point_x,
    output logic [YW-1:0] o_det_point_y,
    input  logic          i_det_point_inside,
    output logic          o_pixel_valid,
    output logic [XW-1:0] o_pixel_x,
    output logic [YW-1:0] o_pixel_y,
    output logic          o_tri_done
);
    localparam int CW = $clog2(DET_LATENCY + 1);
    localparam logic [XW-1:0] X_LIMIT    = XW'(HORIZ_RESOLUTION - 1);
    localparam logic [YW-1:0] Y_LIMIT    = YW'(VERT_RESOLUTION - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DET_LATENCY);
    localparam logic [CW-1:0] DRAIN_PRE  = CW'(DET_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD        = 3'd1,
        ST_WAIT_LOADED = 3'd2,
        ST_SCAN        = 3'd3,
        ST_DRAIN       = 3'd4
    } state_t;

    function automatic logic [XW-1:0] min3_x(input logic [XW-1:0] a, input logic [XW-1:0] b,
                                             input logic [XW-1:0] c);
        logic [XW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [XW-1:0] max3_x(input logic [XW-1:0] a, input logic [XW-1:0] b,
                                             input logic [XW-1:0] c);
        logic [XW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [YW-1:0] min3_y(input logic [YW-1:0] a, input logic [YW-1:0] b,
                                             input logic [YW-1:0] c);
        logic [YW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [YW-1:0] max3_y(input logic [YW-1:0] a, input logic [YW-1:0] b,
                                             input logic [YW-1:0] c);
        logic [YW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    state_t        state_r;
    state_t        state_next_s;
    logic [XW-1:0] vx0_r, vx1_r, vx2_r;
    logic [YW-1:0] vy0_r, vy1_r, vy2_r;
    logic [XW-1:0] min_x_r, max_x_r, pt_x_r;
    logic [YW-1:0] min_y_r, max_y_r, pt_y_r;
    logic [CW-1:0] drain_cnt_r;
    logic          det_load_r;
    logic          done_r;
    logic [XW-1:0] dl_x_r [DET_LATENCY];
    logic [YW-1:0] dl_y_r [DET_LATENCY];
    logic          dl_v_r [DET_LATENCY];

    logic [XW-1:0] tri_min_x_s, tri_max_x_raw_s, tri_max_x_s;
    logic [YW-1:0] tri_min_y_s, tri_max_y_raw_s, tri_max_y_s;
    logic          offscreen_s;
    logic          accept_s;
    logic          last_point_s;
    logic          wrap_s;

    // Bounding box of the offered triangle; the max edge is clipped, the min edge decides off-screen.
    always_comb begin
        tri_min_x_s     = min3_x(i_tri_x0, i_tri_x1, i_tri_x2);
        tri_max_x_raw_s = max3_x(i_tri_x0, i_tri_x1, i_tri_x2);
        tri_min_y_s     = min3_y(i_tri_y0, i_tri_y1, i_tri_y2);
        tri_max_y_raw_s = max3_y(i_tri_y0, i_tri_y1, i_tri_y2);
        tri_max_x_s     = (tri_max_x_raw_s > X_LIMIT) ? X_LIMIT : tri_max_x_raw_s;
        tri_max_y_s     = (tri_max_y_raw_s > Y_LIMIT) ? Y_LIMIT : tri_max_y_raw_s;
        offscreen_s     = (tri_min_x_s > X_LIMIT) || (tri_min_y_s > Y_LIMIT);
        accept_s        = (state_r == ST_IDLE) && i_tri_valid;
        wrap_s          = (pt_x_r == max_x_r);
        last_point_s    = wrap_s && (pt_y_r == max_y_r);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_tri_valid) begin
                    state_next_s = offscreen_s ? ST_DRAIN : ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD:        state_next_s = ST_WAIT_LOADED;
            ST_WAIT_LOADED: begin
                if (i_det_triangle_loaded) begin
                    state_next_s = ST_SCAN;
                end else begin
                    state_next_s = ST_WAIT_LOADED;
                end
            end
            ST_SCAN: begin
                if (last_point_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default:        state_next_s = ST_IDLE;
        endcase
    end

    // State, load strobe, done pulse and drain counter.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_r     <= ST_IDLE;
            det_load_r  <= 1'b0;
            done_r      <= 1'b0;
            drain_cnt_r <= '0;
        end else begin
            state_r     <= state_next_s;
            det_load_r  <= accept_s && !offscreen_s;
            done_r      <= (state_r == ST_DRAIN) && (drain_cnt_r == DRAIN_PRE);
            drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + CW'(1'b1) : '0;
        end
    end

    // Vertex and bounding-box capture; only an IDLE accept may overwrite them.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            vx0_r <= '0; vx1_r <= '0; vx2_r <= '0;
            vy0_r <= '0; vy1_r <= '0; vy2_r <= '0;
            min_x_r <= '0; max_x_r <= '0;
            min_y_r <= '0; max_y_r <= '0;
        end else if (accept_s) begin
            vx0_r <= i_tri_x0; vx1_r <= i_tri_x1; vx2_r <= i_tri_x2;
            vy0_r <= i_tri_y0; vy1_r <= i_tri_y1; vy2_r <= i_tri_y2;
            min_x_r <= tri_min_x_s; max_x_r <= tri_max_x_s;
            min_y_r <= tri_min_y_s; max_y_r <= tri_max_y_s;
        end
    end

    // Raster point generator: x fastest, holds on the final point.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            pt_x_r <= '0;
            pt_y_r <= '0;
        end else if (state_r == ST_LOAD) begin
            pt_x_r <= min_x_r;
            pt_y_r <= min_y_r;
        end else if ((state_r == ST_SCAN) && !last_point_s) begin
            if (wrap_s) begin
                pt_x_r <= min_x_r;
                pt_y_r <= pt_y_r + YW'(1'b1);
            end else begin
                pt_x_r <= pt_x_r + XW'(1'b1);
            end
        end
    end

    // Delay line aligning each presented point with its detector verdict.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < DET_LATENCY; i++) begin
                dl_x_r[i] <= '0;
                dl_y_r[i] <= '0;
                dl_v_r[i] <= 1'b0;
            end
        end else begin
            dl_x_r[0] <= pt_x_r;
            dl_y_r[0] <= pt_y_r;
            dl_v_r[0] <= (state_r == ST_SCAN);
            for (int i = 1; i < DET_LATENCY; i++) begin
                dl_x_r[i] <= dl_x_r[i-1];
                dl_y_r[i] <= dl_y_r[i-1];
                dl_v_r[i] <= dl_v_r[i-1];
            end
        end
    end

    assign o_tri_ready   = (state_r == ST_IDLE);
    assign o_det_load    = det_load_r;
    assign o_det_x0      = vx0_r;
    assign o_det_x1      = vx1_r;
    assign o_det_x2      = vx2_r;
    assign o_det_y0      = vy0_r;
    assign o_det_y1      = vy1_r;
    assign o_det_y2      = vy2_r;
    assign o_det_point_x = pt_x_r;
    assign o_det_point_y = pt_y_r;
    // The verdict is already registered in the detector, so it gates the write directly.
    assign o_pixel_valid = dl_v_r[DET_LATENCY-1] && i_det_point_inside;
    assign o_pixel_x     = dl_x_r[DET_LATENCY-1];
    assign o_pixel_y     = dl_y_r[DET_LATENCY-1];
    assign o_tri_done    = done_r;

endmodule

// File: tb/tb_rasterizer_scan_controller.sv
// Bench for rasterizer_scan_controller: a behavioural detector plus a bbox/raster
// reference model checked cycle by cycle against the controller outputs.
module tb_rasterizer_scan_controller;
    localparam int H  = 80;
    localparam int V  = 60;
    localparam int DL = 2;
    localparam int XW = 7;
    localparam int YW = 6;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          tri_valid = 1'b0;
    logic          tri_ready;
    logic [XW-1:0] tri_x0 = '0, tri_x1 = '0, tri_x2 = '0;
    logic [YW-1:0] tri_y0 = '0, tri_y1 = '0, tri_y2 = '0;
    logic          det_load;
    logic [XW-1:0] det_x0, det_x1, det_x2;
    logic [YW-1:0] det_y0, det_y1, det_y2;
    logic          det_loaded = 1'b1;
    logic [XW-1:0] det_point_x;
    logic [YW-1:0] det_point_y;
    logic          det_inside = 1'b0;
    logic          pixel_valid;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          tri_done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int salt      = 0;
    int nxt [6];

    rasterizer_scan_controller #(
        .HORIZ_RESOLUTION(H), .VERT_RESOLUTION(V), .DET_LATENCY(DL)
    ) dut (
        .i_clk(clk), .i_arst_n(arst_n),
        .i_tri_valid(tri_valid), .o_tri_ready(tri_ready),
        .i_tri_x0(tri_x0), .i_tri_x1(tri_x1), .i_tri_x2(tri_x2),
        .i_tri_y0(tri_y0), .i_tri_y1(tri_y1), .i_tri_y2(tri_y2),
        .o_det_load(det_load),
        .o_det_x0(det_x0), .o_det_x1(det_x1), .o_det_x2(det_x2),
        .o_det_y0(det_y0), .o_det_y1(det_y1), .o_det_y2(det_y2),
        .i_det_triangle_loaded(det_loaded),
        .o_det_point_x(det_point_x), .o_det_point_y(det_point_y),
        .i_det_point_inside(det_inside),
        .o_pixel_valid(pixel_valid), .o_pixel_x(pixel_x), .o_pixel_y(pixel_y),
        .o_tri_done(tri_done)
    );

    always #5 clk = ~clk;

    // Model detector's coverage rule: a salted pattern giving a mix of inside and outside points.
    function automatic bit det_f(input int x, input int y, input int s);
        return ((x * 5 + y * 3 + s) % 4) < 2;
    endfunction

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Detector model: loaded flag drops on the load edge and rises one edge later; verdict has 2 stages.
    logic load_d = 1'b0;
    logic v1 = 1'b0;
    always @(posedge clk) begin
        load_d <= det_load;
        if (det_load) det_loaded <= 1'b0;
        else if (load_d) det_loaded <= 1'b1;
        v1         <= det_f(int'(det_point_x), int'(det_point_y), salt);
        det_inside <= v1;
    end

    // Offer one triangle and check every cycle until ready returns; abort_k > 0 resets at that cycle.
    task automatic run_triangle(input string name, input int x0, input int y0, input int x1,
                                input int y1, input int x2, input int y2,
                                input bit expect_ready, input bit hold, input int abort_k);
        int mnx, mxx, mny, mxy, w, h, area, done_k, idx, wait_n, px, py;
        bit on, exp_pv;
        logic [3*XW+3*YW-1:0] exp_vert;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        salt = int'($urandom_range(0, 1000));
        tri_x0 = x0[XW-1:0]; tri_x1 = x1[XW-1:0]; tri_x2 = x2[XW-1:0];
        tri_y0 = y0[YW-1:0]; tri_y1 = y1[YW-1:0]; tri_y2 = y2[YW-1:0];
        tri_valid = 1'b1;
        if (expect_ready) begin
            total_cnt++;
            if (tri_ready !== 1'b1) $display("FAIL %s ready_first_idle: got %b want 1", name, tri_ready);
            else pass_cnt++;
        end
        wait_n = 0;
        while (tri_ready !== 1'b1 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        if (tri_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL %s ready_timeout: got %b want 1", name, tri_ready);
            tri_valid = 1'b0;
            return;
        end
        @(posedge clk);
        mnx = min3(x0, x1, x2);  mxx = max3(x0, x1, x2);
        mny = min3(y0, y1, y2);  mxy = max3(y0, y1, y2);
        if (mxx > H - 1) mxx = H - 1;
        if (mxy > V - 1) mxy = V - 1;
        on     = (mnx <= H - 1) && (mny <= V - 1);
        w      = mxx - mnx + 1;
        h      = mxy - mny + 1;
        area   = on ? w * h : 0;
        done_k = on ? 4 + area + DL : DL + 1;
        exp_vert = {x0[XW-1:0], x1[XW-1:0], x2[XW-1:0], y0[YW-1:0], y1[YW-1:0], y2[YW-1:0]};
        for (int k = 1; k <= done_k + 1; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                arst_n = 1'b0;
                #1;
                total_cnt++;
                if ({tri_ready, det_load, pixel_valid, tri_done, det_point_x, det_point_y, det_x0}
                    !== {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 7'd0})
                    $display("FAIL %s async_reset: rdy=%b ld=%b pv=%b done=%b pt=(%0d,%0d) x0=%0d want 1,0,0,0,(0,0),0",
                             name, tri_ready, det_load, pixel_valid, tri_done, det_point_x, det_point_y, det_x0);
                else pass_cnt++;
                #2;
                arst_n    = 1'b1;
                tri_valid = 1'b0;
                return;
            end
            total_cnt++;
            if (det_load !== (on && k == 1))
                $display("FAIL %s det_load k=%0d: got %b want %b", name, k, det_load, on && k == 1);
            else pass_cnt++;
            total_cnt++;
            if ({det_x0, det_x1, det_x2, det_y0, det_y1, det_y2} !== exp_vert)
                $display("FAIL %s vertex_hold k=%0d: got x0=%0d y0=%0d want x0=%0d y0=%0d",
                         name, k, det_x0, det_y0, x0, y0);
            else pass_cnt++;
            if (on && k >= 4 && k <= 3 + area) begin
                idx = k - 4;
                ex  = XW'(mnx + idx % w);
                ey  = YW'(mny + idx / w);
                total_cnt++;
                if (det_point_x !== ex || det_point_y !== ey)
                    $display("FAIL %s scan_point k=%0d: got (%0d,%0d) want (%0d,%0d)",
                             name, k, det_point_x, det_point_y, ex, ey);
                else pass_cnt++;
            end
            exp_pv = 1'b0;
            px = 0;
            py = 0;
            if (on && k >= 4 + DL && k <= 3 + DL + area) begin
                idx    = k - 4 - DL;
                px     = mnx + idx % w;
                py     = mny + idx / w;
                exp_pv = det_f(px, py, salt);
            end
            total_cnt++;
            if (pixel_valid !== exp_pv)
                $display("FAIL %s pixel_valid k=%0d: got %b want %b", name, k, pixel_valid, exp_pv);
            else pass_cnt++;
            if (exp_pv) begin
                total_cnt++;
                if (int'(pixel_x) != px || int'(pixel_y) != py)
                    $display("FAIL %s pixel_xy k=%0d: got (%0d,%0d) want (%0d,%0d)",
                             name, k, pixel_x, pixel_y, px, py);
                else pass_cnt++;
            end
            total_cnt++;
            if (tri_done !== (k == done_k))
                $display("FAIL %s tri_done k=%0d: got %b want %b", name, k, tri_done, k == done_k);
            else pass_cnt++;
            total_cnt++;
            if (tri_ready !== (k == done_k + 1))
                $display("FAIL %s tri_ready k=%0d: got %b want %b", name, k, tri_ready, k == done_k + 1);
            else pass_cnt++;
            if (k == 1) begin
                if (hold) begin
                    tri_x0 = nxt[0][XW-1:0]; tri_y0 = nxt[1][YW-1:0];
                    tri_x1 = nxt[2][XW-1:0]; tri_y1 = nxt[3][YW-1:0];
                    tri_x2 = nxt[4][XW-1:0]; tri_y2 = nxt[5][YW-1:0];
                end else begin
                    tri_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        tri_valid = 1'b1;
        tri_x0 = 7'd3; tri_x1 = 7'd9; tri_y2 = 6'd4;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({tri_ready, det_load, pixel_valid, tri_done, det_point_x, det_point_y, pixel_x, det_x1}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, 7'd0, 7'd0})
            $display("FAIL reset_values: rdy=%b ld=%b pv=%b done=%b pt=(%0d,%0d) px=%0d x1=%0d",
                     tri_ready, det_load, pixel_valid, tri_done, det_point_x, det_point_y, pixel_x, det_x1);
        else pass_cnt++;
        tri_valid = 1'b0;
        arst_n    = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({tri_ready, det_load, tri_done} !== 3'b100)
            $display("FAIL reset_release: got rdy/ld/done=%b want 100", {tri_ready, det_load, tri_done});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        run_triangle("basic", 0, 0, 4, 0, 0, 4, 1'b1, 1'b0, 0);
    endtask

    task automatic test_clip();
        run_triangle("clip", 70, 50, 127, 50, 70, 63, 1'b1, 1'b0, 0);
    endtask

    task automatic test_offscreen();
        run_triangle("offscreen_x", 100, 3, 100, 20, 100, 40, 1'b1, 1'b0, 0);
        run_triangle("offscreen_y", 5, 62, 30, 63, 12, 61, 1'b1, 1'b0, 0);
    endtask

    task automatic test_single();
        run_triangle("single", 5, 7, 5, 7, 5, 7, 1'b1, 1'b0, 0);
        run_triangle("corner", 79, 59, 120, 63, 79, 59, 1'b1, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        nxt = '{10, 10, 20, 12, 12, 20};
        run_triangle("hold_first", 2, 3, 9, 3, 2, 8, 1'b1, 1'b1, 0);
        run_triangle("hold_second", nxt[0], nxt[1], nxt[2], nxt[3], nxt[4], nxt[5], 1'b1, 1'b0, 0);
    endtask

    task automatic test_async_reset();
        run_triangle("abort", 0, 0, 4, 0, 0, 4, 1'b1, 1'b0, 12);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({tri_ready, tri_done, pixel_valid, det_load} !== 4'b1000)
                $display("FAIL post_reset_idle cyc=%0d: got rdy/done/pv/ld=%b want 1000",
                         i, {tri_ready, tri_done, pixel_valid, det_load});
            else pass_cnt++;
        end
        run_triangle("after_reset", 30, 20, 36, 25, 33, 28, 1'b1, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            run_triangle("random",
                         int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
                         int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
                         int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
                         1'b1, 1'b0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_offscreen();
        test_single();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
